// File: rtl/data_mem_responder_pkg.sv
// Shared processor constants: opcodes, ALU selects, and the data-memory responder's
// address map defaults and state encodings.
package data_mem_responder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_t;

  localparam logic [31:0] DATA_BASE_DEF  = 32'h1001_0000;
  localparam logic [31:0] CYCLE_ADDR_DEF = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_ERR  = 2'd2
  } dmem_state_t;

  // Which register feeds dReadData.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_CNT  = 2'd2
  } rd_src_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous word RAM with registered read; storage is never reset,
// only the read register is.
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= 32'h0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: decodes MEM-stage accesses into RAM or the cycle counter,
// answering each accepted request with a one-cycle dReady (plus dErr on faults).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] CYCLE_ADDR  = CYCLE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dErr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) * 32'd4;

  dmem_state_t state, state_nxt;
  rd_src_t     rd_src;
  logic        prev_req;
  logic [31:0] cycle_cnt;
  logic [31:0] cnt_cap;
  logic [31:0] ram_rdata;

  logic        req, both, accept, fault;
  logic        ram_ok, cnt_ok, ram_we, ram_re;
  logic [31:0] offset;

  assign req    = MemRead | MemWrite;
  assign both   = MemRead & MemWrite;
  assign offset = dAddress - DATA_BASE;
  assign ram_ok = word_aligned(dAddress) && (dAddress >= DATA_BASE) &&
                  (offset < RAM_BYTES) && !both;
  assign cnt_ok = (dAddress == CYCLE_ADDR) && MemRead && !MemWrite;
  assign fault  = !(ram_ok || cnt_ok);

  // Rising-edge acceptance: a held request level never re-triggers.
  assign accept = req && !prev_req && (state == ST_IDLE);
  assign ram_we = accept && MemWrite && ram_ok;
  assign ram_re = accept && MemRead && ram_ok;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (offset[AW+1:2]),
    .wdata (dWriteData),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      prev_req  <= 1'b0;
      cycle_cnt <= 32'h0;
      cnt_cap   <= 32'h0;
      rd_src    <= SRC_ZERO;
    end else begin
      state     <= state_nxt;
      prev_req  <= req;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept) begin
        if (fault)       rd_src <= SRC_ZERO;
        else if (cnt_ok) rd_src <= SRC_CNT;
        else if (ram_re) rd_src <= SRC_RAM;
        if (cnt_ok) cnt_cap <= cycle_cnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    dReady    = 1'b0;
    dErr      = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = fault ? ST_ERR : ST_RESP;
      ST_RESP: begin
        dReady    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        dReady    = 1'b1;
        dErr      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dReadData = 32'h0;
    case (rd_src)
      SRC_RAM: dReadData = ram_rdata;
      SRC_CNT: dReadData = cnt_cap;
      default: dReadData = 32'h0;
    endcase
  end

endmodule
